// File: rtl/variable_pkg.sv
// Shared game/link constants: player codes, throw frame layout, FSM state type.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package variable_pkg;

    localparam logic [1:0] PLAYER_1 = 2'b01;
    localparam logic [1:0] PLAYER_2 = 2'b10;

    localparam logic [7:0] THROW_FRAME_HEADER = 8'hA5;
    localparam int         THROW_FRAME_LEN    = 4;
    localparam logic [2:0] THROW_FRAME_PAD    = 3'b000;

    typedef enum logic [1:0] {
        TF_IDLE = 2'd0,
        TF_SEND = 2'd1,
        TF_DONE = 2'd2
    } throw_frame_state_t;

    // Fields snapshotted at the moment of the throw.
    typedef struct packed {
        logic [1:0] player;
        logic [2:0] turn;
        logic [6:0] power;
    } throw_meta_t;

    // Byte idx of a frame: header, {player,turn,pad}, {0,power}, XOR of the three.
    function automatic logic [7:0] throw_frame_byte(
        input throw_meta_t m,
        input logic [1:0]  idx,
        input logic [7:0]  header,
        input logic [2:0]  pad
    );
        logic [7:0] b1;
        logic [7:0] b2;
        b1 = {m.player, m.turn, pad};
        b2 = {1'b0, m.power};
        case (idx)
            2'd0:    throw_frame_byte = header;
            2'd1:    throw_frame_byte = b1;
            2'd2:    throw_frame_byte = b2;
            default: throw_frame_byte = header ^ b1 ^ b2;
        endcase
    endfunction

endpackage

// File: rtl/rise_edge_detect.sv
// Registered 1-bit rising-edge detector.
// Latency: rise is combinational from sig against last cycle's sampled value.
// Backpressure: none.
// Ports: clk60MHz/rst (sync, active-high), sig (level in), rise (sig & ~sig last cycle).
module rise_edge_detect (
    input  logic clk60MHz,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic sig_d;

    always_ff @(posedge clk60MHz) begin
        if (rst) begin
            sig_d <= 1'b0;
        end else begin
            sig_d <= sig;
        end
    end

    // A level already high when reset releases reads as a fresh edge.
    assign rise = sig & ~sig_d;

endmodule

// File: rtl/throw_frame_tx.sv
// Throw link transmitter: snapshots a local throw and sends a 4-byte frame to the UART.
// Latency: header byte is offered the cycle after the throw edge; bytes go back-to-back, then 1 guard cycle.
// Backpressure: tx_ready low stalls with tx_data held; throws while busy are dropped with drop_pulse.
// Ports: clk60MHz, rst (sync, active-high); throw_flag, current_player, turn, throw_power (game state);
//        tx_ready / tx_valid / tx_data (byte stream to UART); busy (frame in flight); drop_pulse (throw lost).
module throw_frame_tx
    import variable_pkg::*;
#(
    parameter logic [7:0] FRAME_HEADER = THROW_FRAME_HEADER,
    parameter logic [2:0] PAD_BITS     = THROW_FRAME_PAD
) (
    input  logic       clk60MHz,
    input  logic       rst,
    input  logic       throw_flag,
    input  logic [1:0] current_player,
    input  logic [2:0] turn,
    input  logic [6:0] throw_power,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       busy,
    output logic       drop_pulse
);

    localparam logic [1:0] LAST_IDX = 2'(THROW_FRAME_LEN - 1);

    throw_frame_state_t state;
    throw_meta_t        meta;
    logic [1:0]         byte_idx;
    logic               throw_edge;
    logic               player_ok;
    logic               trigger;

    rise_edge_detect u_throw_edge (
        .clk60MHz (clk60MHz),
        .rst      (rst),
        .sig      (throw_flag),
        .rise     (throw_edge)
    );

    // Edges with no player in play are not throws at all, so they never count as drops.
    assign player_ok = (current_player == PLAYER_1) || (current_player == PLAYER_2);
    assign trigger   = throw_edge & player_ok;

    always_ff @(posedge clk60MHz) begin
        if (rst) begin
            state      <= TF_IDLE;
            meta       <= '0;
            byte_idx   <= 2'd0;
            tx_data    <= 8'h00;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            drop_pulse <= 1'b0;
        end else begin
            drop_pulse <= 1'b0;
            case (state)
                TF_IDLE: begin
                    if (trigger) begin
                        meta.player <= current_player;
                        meta.turn   <= turn;
                        meta.power  <= throw_power;
                        byte_idx    <= 2'd0;
                        tx_data     <= FRAME_HEADER;
                        tx_valid    <= 1'b1;
                        busy        <= 1'b1;
                        state       <= TF_SEND;
                    end
                end
                TF_SEND: begin
                    if (trigger) begin
                        drop_pulse <= 1'b1;
                    end
                    if (tx_ready) begin
                        if (byte_idx == LAST_IDX) begin
                            byte_idx <= 2'd0;
                            tx_data  <= 8'h00;
                            tx_valid <= 1'b0;
                            state    <= TF_DONE;
                        end else begin
                            // Next byte is ready the very next cycle: no bubble between bytes.
                            byte_idx <= byte_idx + 2'd1;
                            tx_data  <= throw_frame_byte(meta, byte_idx + 2'd1, FRAME_HEADER, PAD_BITS);
                        end
                    end
                end
                TF_DONE: begin
                    // Guard gap so the receiver sees a clear frame boundary.
                    if (trigger) begin
                        drop_pulse <= 1'b1;
                    end
                    busy  <= 1'b0;
                    state <= TF_IDLE;
                end
                default: begin
                    state    <= TF_IDLE;
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_throw_frame_tx.sv
module tb_throw_frame_tx;

    logic       clk60MHz = 1'b0;
    logic       rst = 1'b1;
    logic       throw_flag = 1'b0;
    logic [1:0] current_player = 2'b00;
    logic [2:0] turn = 3'd0;
    logic [6:0] throw_power = 7'd0;
    logic       tx_ready = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       busy;
    logic       drop_pulse;

    int n_cmp = 0;
    int n_err = 0;

    throw_frame_tx dut (
        .clk60MHz       (clk60MHz),
        .rst            (rst),
        .throw_flag     (throw_flag),
        .current_player (current_player),
        .turn           (turn),
        .throw_power    (throw_power),
        .tx_ready       (tx_ready),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .busy           (busy),
        .drop_pulse     (drop_pulse)
    );

    always #8 clk60MHz = ~clk60MHz;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Pending bytes of the frame being sent, front = byte on offer.
    logic [7:0] mq[$];
    logic [7:0] cap[$];     // bytes the DUT actually handed over
    bit         m_guard = 0;
    bit         m_drop = 0;
    bit         m_flag_d = 0;
    bit         prev_vld = 0;
    logic [7:0] prev_dat = 8'h00;
    bit         m_edge;
    bit         m_busy_pre;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] exp_dat;

    always @(posedge clk60MHz) begin
        if (!rst && prev_vld && tx_ready) cap.push_back(prev_dat);
        if (rst) begin
            mq.delete();
            cap.delete();
            m_guard  = 0;
            m_drop   = 0;
            m_flag_d = 0;
        end else begin
            m_edge     = throw_flag && !m_flag_d;
            m_busy_pre = (mq.size() != 0) || m_guard;
            m_drop     = 0;
            if (m_guard) m_guard = 0;
            if (mq.size() != 0 && tx_ready) begin
                void'(mq.pop_front());
                if (mq.size() == 0) m_guard = 1;
            end
            if (m_edge && (current_player == 2'd1 || current_player == 2'd2)) begin
                if (m_busy_pre) begin
                    m_drop = 1;
                end else begin
                    b1 = 8'(current_player * 64 + turn * 8);
                    b2 = 8'(throw_power);
                    mq.push_back(8'hA5);
                    mq.push_back(b1);
                    mq.push_back(b2);
                    mq.push_back(8'hA5 ^ b1 ^ b2);
                end
            end
            m_flag_d = throw_flag;
        end
        #1;
        exp_dat = (mq.size() != 0) ? mq[0] : 8'h00;
        chk("model tx_valid", tx_valid, (mq.size() != 0));
        chk("model tx_data", tx_data, exp_dat);
        chk("model busy", busy, ((mq.size() != 0) || m_guard));
        chk("model drop_pulse", drop_pulse, m_drop);
        prev_vld = tx_valid;
        prev_dat = tx_data;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk60MHz);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (!busy) break;
            tick();
        end
        chk("wait_idle timeout busy", busy, 0);
    endtask

    task automatic check_frame(input string name, input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] e[4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        chk({name, " byte count"}, cap.size(), 4);
        for (int i = 0; i < 4 && i < cap.size(); i++) chk({name, " byte"}, cap[i], e[i]);
    endtask

    task automatic set_fields(input logic [1:0] p, input logic [2:0] t, input logic [6:0] pw);
        current_player = p;
        turn           = t;
        throw_power    = pw;
    endtask

    initial begin
        logic [7:0] nom[4];
        nom[0] = 8'hA5; nom[1] = 8'h58; nom[2] = 8'h40; nom[3] = 8'hBD;

        // Reset state
        repeat (3) tick();
        chk("reset tx_valid", tx_valid, 0);
        chk("reset tx_data", tx_data, 8'h00);
        chk("reset busy", busy, 0);
        chk("reset drop_pulse", drop_pulse, 0);
        rst = 1'b0;
        tick();

        // Nominal frame, tx_ready always high
        set_fields(2'b01, 3'd3, 7'h40);
        tx_ready = 1'b1;
        tick();
        cap.delete();
        throw_flag = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("nominal valid", tx_valid, 1);
            chk("nominal data", tx_data, nom[i]);
        end
        tick();
        chk("nominal guard valid", tx_valid, 0);
        chk("nominal guard busy", busy, 1);
        tick();
        chk("nominal idle busy", busy, 0);
        check_frame("nominal", 8'hA5, 8'h58, 8'h40, 8'hBD);
        throw_flag = 1'b0;
        tick();

        // Backpressure on B1
        cap.delete();
        throw_flag = 1'b1;
        tick();                 // A5 offered
        tick();                 // 58 offered
        chk("bp first B1", tx_data, 8'h58);
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp hold valid", tx_valid, 1);
            chk("bp hold data", tx_data, 8'h58);
        end
        tx_ready = 1'b1;
        tick();
        wait_idle();
        check_frame("backpressure", 8'hA5, 8'h58, 8'h40, 8'hBD);
        throw_flag = 1'b0;
        tick();

        // Throw during SEND is dropped
        cap.delete();
        tx_ready   = 1'b0;
        throw_flag = 1'b1;
        tick();
        throw_flag = 1'b0;
        tick();
        throw_flag = 1'b1;
        set_fields(2'b10, 3'd5, 7'h11);
        tick();
        chk("drop pulse high", drop_pulse, 1);
        tick();
        chk("drop pulse one cycle", drop_pulse, 0);
        tx_ready = 1'b1;
        wait_idle();
        check_frame("dropped", 8'hA5, 8'h58, 8'h40, 8'hBD);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("no second frame", tx_valid, 0);
        end
        throw_flag = 1'b0;
        tick();

        // Invalid player
        set_fields(2'b00, 3'd2, 7'h22);
        throw_flag = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("invalid valid", tx_valid, 0);
            chk("invalid busy", busy, 0);
            chk("invalid drop", drop_pulse, 0);
        end
        throw_flag = 1'b0;
        tick();

        // Field snapshot
        cap.delete();
        set_fields(2'b10, 3'd7, 7'h7F);
        throw_flag = 1'b1;
        tick();
        set_fields(2'b01, 3'd0, 7'h00);
        tick();
        wait_idle();
        check_frame("snapshot", 8'hA5, 8'hB8, 8'h7F, 8'h62);
        throw_flag = 1'b0;
        tick();

        // Reset mid-frame with throw_flag held high
        set_fields(2'b01, 3'd3, 7'h40);
        throw_flag = 1'b1;
        tick();
        tick();
        tick();
        chk("rst pre B2", tx_data, 8'h40);
        rst = 1'b1;
        tick();
        chk("rst mid valid", tx_valid, 0);
        chk("rst mid busy", busy, 0);
        chk("rst mid data", tx_data, 8'h00);
        rst = 1'b0;
        tick();
        chk("post-rst restart valid", tx_valid, 1);
        chk("post-rst restart data", tx_data, 8'hA5);
        wait_idle();
        check_frame("post-reset", 8'hA5, 8'h58, 8'h40, 8'hBD);
        throw_flag = 1'b0;
        tick();

        // Randomised traffic, checked by the model every cycle
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) throw_flag = ~throw_flag;
            tx_ready       = ($urandom_range(0, 3) != 0);
            current_player = 2'($urandom_range(0, 3));
            turn           = 3'($urandom);
            throw_power    = 7'($urandom);
            rst            = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
